regfile_write_scheduler: RTL and testbench

- Shares the single register-file write port (rw/dw/rwe) between two writeback requesters: A = ALU writeback, B = memory-load writeback.
- Uses valid/ready handshakes and round-robin arbitration, with one registered write stage.
- After reset, a sequencer writes zero to every register, because the register file has no reset of its own.
- Forwards the in-flight write onto the read outputs (crs/crt) so readers never see stale data.
- Sits between the writeback stage and Register_File.

---
 rtl/regfile_sched_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/regfile_write_scheduler.sv | 138 +++++++++++++
 tb/tb_regfile_write_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
//   sched_state_t : INIT (clearing the register file) / RUN (arbitrating)
//   REQ_A, REQ_B  : requester ids, also the bit index of each requester in
//                   the arbiter valid/grant vectors
//   DATA_W_DEF, ADDR_W_DEF : default widths for the scheduler
package regfile_sched_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
//   valid[1:0] : request lines, bit REQ_A = requester A, bit REQ_B = requester B
//   last       : id of the requester that won most recently
//   grant[1:0] : one-hot grant (all zero when nothing is requested)
module rr_arbiter2
    import regfile_sched_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        // On contention the requester that did not win last time gets the port.
        if (valid[0] && valid[1]) begin
            grant = 2'b00;
            if (last == REQ_A) begin
                grant[REQ_B] = 1'b1;
            end else begin
                grant[REQ_A] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port between ALU writeback (A) and
// memory-load writeback (B), clears the register file after reset, and
// forwards the in-flight write onto the read data.
//   clk, rst_n                    : clock, async active-low reset
//   a_valid/a_ready/a_addr/a_data : requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data : requester B handshake and payload
//   rw, dw, rwe                   : registered register-file write port
//   rs, rt                        : read addresses (also go to the register file)
//   crs_rf, crt_rf                : raw register-file read data
//   crs, crt                      : forwarded read data
//   init_done                     : clear sequence complete, arbitration live
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | one zero write per cycle to addresses 0..NUM_REGS-1, no grants
// RUN   | round-robin arbitration, one accepted write per cycle
module regfile_write_scheduler
    import regfile_sched_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] rw,
    output logic [DATA_W-1:0] dw,
    output logic              rwe,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] crs_rf,
    input  logic [DATA_W-1:0] crt_rf,
    output logic [DATA_W-1:0] crs,
    output logic [DATA_W-1:0] crt,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              rr_last;
    logic [1:0]        grant;
    logic              xfer_a;
    logic              xfer_b;

    rr_arbiter2 u_arb (
        .valid ({b_valid, a_valid}),
        .last  (rr_last),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        case (state)
            INIT: begin
                if (cnt == LAST_REG) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                a_ready = grant[REQ_A];
                b_ready = grant[REQ_B];
            end
            default: state_nxt = INIT;
        endcase
    end

    assign xfer_a    = a_valid && a_ready;
    assign xfer_b    = b_valid && b_ready;
    assign init_done = (state == RUN);

    // Output write stage. Register 0 is hardwired to zero, so a write to it
    // is accepted but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            rr_last <= REQ_B;
            rw      <= '0;
            dw      <= '0;
            rwe     <= 1'b0;
        end else if (state == INIT) begin
            rw  <= cnt;
            dw  <= '0;
            rwe <= 1'b1;
            cnt <= cnt + 1'b1;
        end else if (xfer_a) begin
            rw      <= a_addr;
            dw      <= a_data;
            rwe     <= (a_addr != '0);
            rr_last <= REQ_A;
        end else if (xfer_b) begin
            rw      <= b_addr;
            dw      <= b_data;
            rwe     <= (b_addr != '0);
            rr_last <= REQ_B;
        end else begin
            rwe <= 1'b0;
        end
    end

    // The register file commits at the end of the rwe cycle, so a read of
    // the same address during that cycle must take dw instead.
    always_comb begin
        crs = crs_rf;
        if (rs == '0) begin
            crs = '0;
        end else if (rwe && (rw == rs)) begin
            crs = dw;
        end
        crt = crt_rf;
        if (rt == '0) begin
            crt = '0;
        end else if (rwe && (rw == rt)) begin
            crt = dw;
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler. A behavioural register
// file sits on the write/read ports; a separate model of the architectural
// register contents, the round-robin winner and the in-flight write supplies
// every expected value.
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, rw, rs, rt;
    logic [31:0] a_data, b_data, dw, crs_rf, crt_rf, crs, crt;
    logic        rwe, init_done;

    regfile_write_scheduler #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rw(rw), .dw(dw), .rwe(rwe),
        .rs(rs), .rt(rt), .crs_rf(crs_rf), .crt_rf(crt_rf),
        .crs(crs), .crt(crt), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Behavioural register file: power-up garbage until first written.
    logic [31:0] garbage [32];
    logic [31:0] rf_mem  [32];
    logic [31:0] wr_flag;

    always @(posedge clk) begin
        if (rwe) begin
            rf_mem[rw]  <= dw;
            wr_flag[rw] <= 1'b1;
        end
    end

    assign crs_rf = (wr_flag[rs] === 1'b1) ? rf_mem[rs] : garbage[rs];
    assign crt_rf = (wr_flag[rt] === 1'b1) ? rf_mem[rt] : garbage[rt];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] exp_rf [32];
    logic        model_last;   // 0 = A won last, 1 = B won last
    logic        exp_we;
    logic [4:0]  exp_rw_m;
    logic [31:0] exp_dw_m;
    logic        win_a, win_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (exp_we && exp_rw_m == addr) return exp_dw_m;
        return exp_rf[addr];
    endfunction

    // Requests are held valid throughout the clear; none may be granted
    // until the cycle in which init_done rises.
    task automatic init_seq();
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'hDEAD0004;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'hDEAD0006;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("init_rwe", rwe, 1'b1);
            chk("init_rw", rw, i);
            chk("init_dw", dw, 32'h0);
            chk("init_done", init_done, (i == 31));
            if (i < 31) begin
                chk("init_a_ready", a_ready, 1'b0);
                chk("init_b_ready", b_ready, 1'b0);
            end else begin
                chk("first_grant_a", a_ready, 1'b1);
                chk("first_grant_b", b_ready, 1'b0);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        chk("post_init_rwe", rwe, 1'b0);
        for (int r = 0; r < 32; r++) exp_rf[r] = 32'h0;
        exp_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) garbage[i] = $urandom | 32'h1;
        rst_n = 1'b0;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h2;
        rs = 5'd0; rt = 5'd0;
        tick(); tick(); tick();
        chk("rst_rwe", rwe, 1'b0);
        chk("rst_rw", rw, 5'd0);
        chk("rst_dw", dw, 32'h0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        rst_n = 1'b1;
        init_seq();

        // Every register reads zero after the clear.
        for (int r = 0; r < 32; r++) begin
            rs = 5'(r); rt = 5'(31 - r);
            #1;
            chk("clear_crs", crs, 32'h0);
            chk("clear_crt", crt, 32'h0);
        end

        // Contention: A first (rr_last=B after reset), then alternate.
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hA001;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'hB008;
        #1;
        chk("rr0_a_ready", a_ready, 1'b1);
        chk("rr0_b_ready", b_ready, 1'b0);
        tick();
        chk("rr0_rw", rw, 5'd1); chk("rr0_dw", dw, 32'hA001); chk("rr0_rwe", rwe, 1'b1);
        a_addr = 5'd2; a_data = 32'hA002;
        #1;
        chk("rr1_a_ready", a_ready, 1'b0);
        chk("rr1_b_ready", b_ready, 1'b1);
        tick();
        chk("rr1_rw", rw, 5'd8); chk("rr1_dw", dw, 32'hB008); chk("rr1_rwe", rwe, 1'b1);
        b_addr = 5'd9; b_data = 32'hB009;
        #1;
        chk("rr2_a_ready", a_ready, 1'b1);
        chk("rr2_b_ready", b_ready, 1'b0);
        tick();
        chk("rr2_rw", rw, 5'd2); chk("rr2_rwe", rwe, 1'b1);
        a_valid = 1'b0;
        #1;
        chk("rr3_a_ready", a_ready, 1'b0);
        chk("rr3_b_ready", b_ready, 1'b1);
        tick();
        chk("rr3_rw", rw, 5'd9); chk("rr3_dw", dw, 32'hB009); chk("rr3_rwe", rwe, 1'b1);
        b_valid = 1'b0;
        tick();
        chk("rr_idle_rwe", rwe, 1'b0);
        chk("rr_hold_rw", rw, 5'd9);
        chk("rr_hold_dw", dw, 32'hB009);
        exp_rf[1] = 32'hA001; exp_rf[8] = 32'hB008;
        exp_rf[2] = 32'hA002; exp_rf[9] = 32'hB009;

        // A only, with forwarding then register-file read.
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000A52A;
        #1;
        chk("aonly_a_ready", a_ready, 1'b1);
        chk("aonly_b_ready", b_ready, 1'b0);
        tick();
        a_valid = 1'b0; rs = 5'd3;
        #1;
        chk("aonly_rw", rw, 5'd3); chk("aonly_dw", dw, 32'h0000A52A);
        chk("aonly_rwe", rwe, 1'b1);
        chk("aonly_fwd_crs", crs, 32'h0000A52A);
        tick();
        chk("aonly_rwe_off", rwe, 1'b0);
        chk("aonly_rf_crs", crs, 32'h0000A52A);
        exp_rf[3] = 32'h0000A52A;

        // B writes register 0: accepted, never enabled, reads stay zero.
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
        #1;
        chk("r0_b_ready", b_ready, 1'b1);
        chk("r0_a_ready", a_ready, 1'b0);
        tick();
        b_valid = 1'b0; rs = 5'd0;
        #1;
        chk("r0_rwe", rwe, 1'b0);
        chk("r0_crs", crs, 32'h0);
        tick();

        // Forwarding on both ports, and no forwarding to a different address.
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h12345678;
        #1;
        chk("fwd_a_ready", a_ready, 1'b1);
        tick();
        a_valid = 1'b0; rs = 5'd5; rt = 5'd5;
        #1;
        chk("fwd_crs", crs, 32'h12345678);
        chk("fwd_crt", crt, 32'h12345678);
        rs = 5'd6;
        #1;
        chk("fwd_other_crs", crs, exp_rf[6]);
        chk("fwd_other_crt", crt, 32'h12345678);
        tick();
        chk("fwd_rwe_off", rwe, 1'b0);
        exp_rf[5] = 32'h12345678;
        model_last = 1'b0;
        exp_we = 1'b0; exp_rw_m = 5'd5; exp_dw_m = 32'h12345678;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            if (!a_valid) begin
                a_valid = 1'($urandom_range(0, 1));
                a_addr  = 5'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid) begin
                b_valid = 1'($urandom_range(0, 1));
                b_addr  = 5'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            rs = 5'($urandom_range(0, 31));
            rt = (n % 4 == 0) ? exp_rw_m : 5'($urandom_range(0, 31));
            #1;
            win_a = a_valid && (!b_valid || model_last);
            win_b = b_valid && !win_a;
            chk("rnd_a_ready", a_ready, win_a);
            chk("rnd_b_ready", b_ready, win_b);
            chk("rnd_crs", crs, fwd(rs));
            chk("rnd_crt", crt, fwd(rt));
            tick();
            if (exp_we) exp_rf[exp_rw_m] = exp_dw_m;
            exp_we = 1'b0;
            if (win_a) begin
                exp_rw_m = a_addr; exp_dw_m = a_data;
                exp_we = (a_addr != 5'd0); model_last = 1'b0;
                a_valid = 1'b0;
            end else if (win_b) begin
                exp_rw_m = b_addr; exp_dw_m = b_data;
                exp_we = (b_addr != 5'd0); model_last = 1'b1;
                b_valid = 1'b0;
            end
            chk("rnd_rwe", rwe, exp_we);
            chk("rnd_rw", rw, exp_rw_m);
            chk("rnd_dw", dw, exp_dw_m);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // Reset while a write is in flight.
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h77777777;
        #1;
        tick();
        a_valid = 1'b0;
        chk("midrst_pre_rwe", rwe, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rwe", rwe, 1'b0);
        chk("midrst_init_done", init_done, 1'b0);
        chk("midrst_rw", rw, 5'd0);
        chk("midrst_a_ready", a_ready, 1'b0);
        #1;
        rst_n = 1'b1;
        init_seq();
        rs = 5'd7; rt = 5'd5;
        #1;
        chk("reclear_crs", crs, 32'h0);
        chk("reclear_crt", crt, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
